// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the 6502 memory responder: region bases, reset vector,
// the one-hot controller state encoding and the read-source select.
package mem_ctrl_pkg;

   localparam int LOAD_IDX    = 0;
   localparam int RELEASE_IDX = 1;
   localparam int RUN_IDX     = 2;

   typedef enum logic [2:0] {
      ST_LOAD    = 3'(1 << LOAD_IDX),
      ST_RELEASE = 3'(1 << RELEASE_IDX),
      ST_RUN     = 3'(1 << RUN_IDX)
   } state_e;

   typedef enum logic [1:0] {
      SEL_OPEN,
      SEL_RAM,
      SEL_ROM
   } sel_e;

   localparam logic [15:0] RAM_BASE     = 16'h0000;
   localparam logic [15:0] ROM_BASE     = 16'hF000;
   localparam logic [15:0] RESET_VEC_LO = 16'hFFFC;
   localparam logic [15:0] RESET_VEC_HI = 16'hFFFD;

   localparam logic [7:0] OPEN_BUS_DEFAULT = 8'hFF;

endpackage

// File: rtl/mem_sp_ram.sv
// Single-port synchronous RAM: one registered read per cycle, read-before-write.
module mem_sp_ram #(
   parameter int AW = 11,
   parameter int DW = 8
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o
);

   logic [DW-1:0] mem [2**AW];
   logic [DW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem[addr_i] <= wdata_i;
      end
      rdata_q <= mem[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_ctrl.sv
// Memory responder for the 6502 bus: RAM/ROM/open-bus decode plus a bootstrap
// loader that fills ROM and holds the core in reset until the load completes.
module mem_ctrl
   import mem_ctrl_pkg::*;
#(
   parameter int          RAM_AW         = 11,
   parameter int          ROM_AW         = 12,
   parameter int          RELEASE_CYCLES = 4,
   parameter logic [7:0]  OPEN_BUS       = OPEN_BUS_DEFAULT
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic [15:0] address,
   input  logic [7:0]  wr_data,
   input  logic        wr_enable,
   output logic [7:0]  rd_data,
   input  logic        load_valid,
   input  logic [7:0]  load_data,
   input  logic        load_last,
   output logic        load_ready,
   output logic        cpu_resetn,
   output logic        load_done,
   output logic [7:0]  unmapped_cnt
);

   if (RAM_AW >= 16 || ROM_AW >= 16 || RAM_AW < 1 || ROM_AW < 1) begin : g_bad_aw
      $error("mem_ctrl: RAM_AW and ROM_AW must be in 1..15");
   end
   if ((2**RAM_AW) + (2**ROM_AW) > 65536) begin : g_overlap
      $error("mem_ctrl: RAM and ROM regions overlap");
   end
   if (RELEASE_CYCLES < 1 || RELEASE_CYCLES > 255) begin : g_bad_rel
      $error("mem_ctrl: RELEASE_CYCLES must be in 1..255");
   end

   state_e            state_q;
   sel_e              sel_q;
   logic [ROM_AW-1:0] ptr_q;
   logic [7:0]        rel_cnt_q;
   logic [7:0]        unmapped_q;
   logic              load_ready_q;
   logic              load_done_q;
   logic              cpu_resetn_q;

   logic              in_ram;
   logic              in_rom;
   logic              run;
   logic              accept;
   logic              ram_we;
   logic [7:0]        ram_rdata;
   logic              rom_we;
   logic [ROM_AW-1:0] rom_addr;
   logic [7:0]        rom_rdata;

   assign in_ram   = (address[15:RAM_AW] == '0);
   assign in_rom   = (&address[15:ROM_AW]);
   assign run      = (state_q == ST_RUN);
   assign accept   = load_valid && load_ready_q;
   assign ram_we   = run && wr_enable && in_ram;
   // ROM port belongs to the loader while loading and is read-only afterwards.
   assign rom_we   = accept;
   assign rom_addr = (state_q == ST_LOAD) ? ptr_q : address[ROM_AW-1:0];

   mem_sp_ram #(.AW(RAM_AW), .DW(8)) u_ram (
      .clk     (clk),
      .we_i    (ram_we),
      .addr_i  (address[RAM_AW-1:0]),
      .wdata_i (wr_data),
      .rdata_o (ram_rdata)
   );

   mem_sp_ram #(.AW(ROM_AW), .DW(8)) u_rom (
      .clk     (clk),
      .we_i    (rom_we),
      .addr_i  (rom_addr),
      .wdata_i (load_data),
      .rdata_o (rom_rdata)
   );

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= ST_LOAD;
         sel_q        <= SEL_OPEN;
         ptr_q        <= '0;
         rel_cnt_q    <= '0;
         unmapped_q   <= '0;
         load_ready_q <= 1'b0;
         load_done_q  <= 1'b0;
         cpu_resetn_q <= 1'b0;
      end else begin
         sel_q <= SEL_OPEN;
         unique case (state_q)
            ST_LOAD: begin
               load_ready_q <= 1'b1;
               if (accept) begin
                  if (ptr_q != '1) begin
                     ptr_q <= ptr_q + 1'b1;
                  end
                  if (load_last || ptr_q == '1) begin
                     state_q      <= ST_RELEASE;
                     load_ready_q <= 1'b0;
                     load_done_q  <= 1'b1;
                  end
               end
            end
            ST_RELEASE: begin
               if (rel_cnt_q == 8'(RELEASE_CYCLES - 1)) begin
                  state_q      <= ST_RUN;
                  cpu_resetn_q <= 1'b1;
               end else begin
                  rel_cnt_q <= rel_cnt_q + 1'b1;
               end
            end
            ST_RUN: begin
               if (in_ram) begin
                  sel_q <= SEL_RAM;
               end else if (in_rom) begin
                  sel_q <= SEL_ROM;
               end else if (unmapped_q != 8'hFF) begin
                  unmapped_q <= unmapped_q + 1'b1;
               end
            end
            default: state_q <= ST_LOAD;
         endcase
      end
   end

   // sel_q tracks the region of last cycle's address, aligning with the RAM output register.
   always_comb begin
      rd_data = OPEN_BUS;
      case (sel_q)
         SEL_RAM: rd_data = ram_rdata;
         SEL_ROM: rd_data = rom_rdata;
         default: rd_data = OPEN_BUS;
      endcase
   end

   assign load_ready   = load_ready_q;
   assign load_done    = load_done_q;
   assign cpu_resetn   = cpu_resetn_q;
   assign unmapped_cnt = unmapped_q;

endmodule
